issue_window: RTL and testbench

ISSUE_WINDOW -- requirements
Module: issue_window

---
 rtl/issue_window.sv | 172 +++++++++++++++++
 tb/tb_issue_window.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/issue_window.sv
// Multi-lane in-order issue window: circular buffer of decoded ops that issues
// the longest hazard-free prefix from the head each cycle.
module issue_window #(
    parameter int ISSUE_W   = 2,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [ISSUE_W-1:0]             in_valid,
    output logic                           in_ready,
    input  logic [5*ISSUE_W-1:0]           in_dst,
    input  logic [5*ISSUE_W-1:0]           in_rs,
    input  logic [5*ISSUE_W-1:0]           in_rt,
    input  logic [ISSUE_W-1:0]             in_wr,
    input  logic [ISSUE_W-1:0]             in_mhi,
    input  logic [ISSUE_W-1:0]             in_mlo,
    input  logic [ISSUE_W-1:0]             in_nhi,
    input  logic [ISSUE_W-1:0]             in_nlo,
    input  logic [ISSUE_W-1:0]             in_load,
    input  logic [ISSUE_W-1:0]             in_serial,
    input  logic [PAYLOAD_W*ISSUE_W-1:0]   in_payload,
    input  logic [ISSUE_W-1:0]             ex_load_valid,
    input  logic [5*ISSUE_W-1:0]           ex_load_dst,
    input  logic                           ex_ready,
    output logic [ISSUE_W-1:0]             out_valid,
    output logic [5*ISSUE_W-1:0]           out_dst,
    output logic [5*ISSUE_W-1:0]           out_rs,
    output logic [5*ISSUE_W-1:0]           out_rt,
    output logic [ISSUE_W-1:0]             out_wr,
    output logic [ISSUE_W-1:0]             out_mhi,
    output logic [ISSUE_W-1:0]             out_mlo,
    output logic [ISSUE_W-1:0]             out_nhi,
    output logic [ISSUE_W-1:0]             out_nlo,
    output logic [ISSUE_W-1:0]             out_load,
    output logic [ISSUE_W-1:0]             out_serial,
    output logic [PAYLOAD_W*ISSUE_W-1:0]   out_payload,
    output logic [31:0]                    stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [4:0]           dst;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic                 wr;
        logic                 mhi;
        logic                 mlo;
        logic                 nhi;
        logic                 nlo;
        logic                 load;
        logic                 serial;
    } op_t;

    op_t              mem [DEPTH];
    op_t              in_op [ISSUE_W];
    op_t              cand [ISSUE_W];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, enq_n, pop_n, issue_k;
    logic             do_enq, stall;

    assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(ISSUE_W);
    assign do_enq   = in_ready && !flush;

    always_comb begin
        enq_n = '0;
        for (int unsigned l = 0; l < ISSUE_W; l++) begin
            in_op[l].payload = in_payload[PAYLOAD_W*l +: PAYLOAD_W];
            in_op[l].dst     = in_dst[5*l +: 5];
            in_op[l].rs      = in_rs[5*l +: 5];
            in_op[l].rt      = in_rt[5*l +: 5];
            in_op[l].wr      = in_wr[l];
            in_op[l].mhi     = in_mhi[l];
            in_op[l].mlo     = in_mlo[l];
            in_op[l].nhi     = in_nhi[l];
            in_op[l].nlo     = in_nlo[l];
            in_op[l].load    = in_load[l];
            in_op[l].serial  = in_serial[l];
            if (in_valid[l]) enq_n = enq_n + CNT_W'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            cand[i] = mem[head + PTR_W'(i)];
        end
    end

    // Lanes are accepted in order; the first blocked lane ends the bundle.
    always_comb begin
        logic blocked;
        logic hit;
        blocked   = flush;
        issue_k   = '0;
        out_valid = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            hit = !(CNT_W'(i) < count);
            if (i > 0 && (cand[i].serial || cand[0].serial)) hit = 1'b1;
            for (int unsigned j = 0; j < ISSUE_W; j++) begin
                if (j < i) begin
                    if (cand[j].wr && cand[j].dst != 5'd0 &&
                        (cand[j].dst == cand[i].rs || cand[j].dst == cand[i].rt)) hit = 1'b1;
                    if (cand[j].mhi && cand[i].nhi) hit = 1'b1;
                    if (cand[j].mlo && cand[i].nlo) hit = 1'b1;
                end
            end
            for (int unsigned e = 0; e < ISSUE_W; e++) begin
                if (ex_load_valid[e] && ex_load_dst[5*e +: 5] != 5'd0 &&
                    (ex_load_dst[5*e +: 5] == cand[i].rs ||
                     ex_load_dst[5*e +: 5] == cand[i].rt)) hit = 1'b1;
            end
            if (blocked || hit) begin
                blocked = 1'b1;
            end else begin
                out_valid[i] = 1'b1;
                issue_k      = issue_k + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            out_payload[PAYLOAD_W*i +: PAYLOAD_W] = cand[i].payload;
            out_dst[5*i +: 5] = cand[i].dst;
            out_rs[5*i +: 5]  = cand[i].rs;
            out_rt[5*i +: 5]  = cand[i].rt;
            out_wr[i]         = cand[i].wr;
            out_mhi[i]        = cand[i].mhi;
            out_mlo[i]        = cand[i].mlo;
            out_nhi[i]        = cand[i].nhi;
            out_nlo[i]        = cand[i].nlo;
            out_load[i]       = cand[i].load;
            out_serial[i]     = cand[i].serial;
        end
    end

    assign pop_n = ex_ready ? issue_k : '0;
    assign stall = (count != '0) && (issue_k == '0 || !ex_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_enq) tail <= tail + PTR_W'(enq_n);
                head  <= head + PTR_W'(pop_n);
                count <= count + (do_enq ? enq_n : '0) - pop_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int unsigned l = 0; l < ISSUE_W; l++) begin
                if (in_valid[l]) mem[tail + PTR_W'(l)] <= in_op[l];
            end
        end
    end

endmodule

// File: tb/tb_issue_window.sv
// Directed scenario bench for issue_window at ISSUE_W=2, DEPTH=4, PAYLOAD_W=64.
module tb_issue_window;

    logic         clk = 1'b0;
    logic         reset, flush, in_ready, ex_ready;
    logic [1:0]   in_valid, in_wr, in_mhi, in_mlo, in_nhi, in_nlo, in_load, in_serial;
    logic [9:0]   in_dst, in_rs, in_rt, ex_load_dst;
    logic [127:0] in_payload, out_payload;
    logic [1:0]   ex_load_valid, out_valid, out_wr, out_mhi, out_mlo, out_nhi, out_nlo;
    logic [1:0]   out_load, out_serial;
    logic [9:0]   out_dst, out_rs, out_rt;
    logic [31:0]  stall_cnt;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    issue_window #(.ISSUE_W(2), .DEPTH(4), .PAYLOAD_W(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dst(in_dst), .in_rs(in_rs), .in_rt(in_rt),
        .in_wr(in_wr), .in_mhi(in_mhi), .in_mlo(in_mlo), .in_nhi(in_nhi),
        .in_nlo(in_nlo), .in_load(in_load), .in_serial(in_serial),
        .in_payload(in_payload),
        .ex_load_valid(ex_load_valid), .ex_load_dst(ex_load_dst), .ex_ready(ex_ready),
        .out_valid(out_valid), .out_dst(out_dst), .out_rs(out_rs), .out_rt(out_rt),
        .out_wr(out_wr), .out_mhi(out_mhi), .out_mlo(out_mlo), .out_nhi(out_nhi),
        .out_nlo(out_nlo), .out_load(out_load), .out_serial(out_serial),
        .out_payload(out_payload), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = '0; in_dst = '0; in_rs = '0; in_rt = '0;
        in_wr = '0; in_mhi = '0; in_mlo = '0; in_nhi = '0; in_nlo = '0;
        in_load = '0; in_serial = '0; in_payload = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] dst, input logic [4:0] rs,
                            input logic [4:0] rt, input logic serial, input logic [63:0] pl);
        in_valid[l]          = 1'b1;
        in_dst[5*l +: 5]     = dst;
        in_rs[5*l +: 5]      = rs;
        in_rt[5*l +: 5]      = rt;
        in_wr[l]             = 1'b1;
        in_serial[l]         = serial;
        in_payload[64*l +: 64] = pl;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL reset_out_valid got=%b exp=00", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_dual_issue();
        ex_ready = 1'b1;
        clear_in(); set_lane(0, 5'd3, 5'd1, 5'd2, 1'b0, 64'hA0); set_lane(1, 5'd4, 5'd1, 5'd2, 1'b0, 64'hA1);
        #1;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL no_bypass got=%b exp=00", out_valid); else pass_cnt++;
        tick(); clear_in();
        total_cnt++; if (out_valid !== 2'b11) $display("FAIL dual_valid got=%b exp=11", out_valid); else pass_cnt++;
        total_cnt++; if (out_dst !== {5'd4, 5'd3}) $display("FAIL dual_dst got=%h exp=%h", out_dst, {5'd4, 5'd3}); else pass_cnt++;
        total_cnt++; if (out_payload[127:64] !== 64'hA1) $display("FAIL dual_payload1 got=%h exp=a1", out_payload[127:64]); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL dual_empty got=%b exp=00", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL dual_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_raw();
        clear_in(); set_lane(0, 5'd5, 5'd1, 5'd2, 1'b0, 64'hB0); set_lane(1, 5'd6, 5'd5, 5'd0, 1'b0, 64'hB1);
        tick(); clear_in();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL raw_c1_valid got=%b exp=01", out_valid); else pass_cnt++;
        total_cnt++; if (out_dst[4:0] !== 5'd5) $display("FAIL raw_c1_dst got=%0d exp=5", out_dst[4:0]); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL raw_c2_valid got=%b exp=01", out_valid); else pass_cnt++;
        total_cnt++; if (out_dst[4:0] !== 5'd6) $display("FAIL raw_c2_dst got=%0d exp=6", out_dst[4:0]); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL raw_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
        tick();
        // HI dependency: mult-like op then mfhi-like op
        clear_in(); set_lane(0, 5'd0, 5'd1, 5'd2, 1'b0, 64'hB2); set_lane(1, 5'd7, 5'd0, 5'd0, 1'b0, 64'hB3);
        in_wr[0] = 1'b0; in_mhi[0] = 1'b1; in_nhi[1] = 1'b1;
        tick(); clear_in();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL hi_dep_valid got=%b exp=01", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_payload[63:0] !== 64'hB3) $display("FAIL hi_dep_second got=%h exp=b3", out_payload[63:0]); else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        clear_in(); set_lane(0, 5'd8, 5'd7, 5'd0, 1'b0, 64'hC0);
        tick(); clear_in();
        ex_load_valid = 2'b01; ex_load_dst = {5'd0, 5'd7};
        #1;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL load_use_blocked got=%b exp=00", out_valid); else pass_cnt++;
        tick();
        ex_load_valid = 2'b00; ex_load_dst = '0;
        #1;
        total_cnt++; if (stall_cnt !== 32'd1) $display("FAIL load_use_stall got=%0d exp=1", stall_cnt); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL load_use_release got=%b exp=01", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 32'd1) $display("FAIL load_use_stall_hold got=%0d exp=1", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_fill_wrap();
        ex_ready = 1'b0;
        clear_in(); set_lane(0, 5'd10, 5'd0, 5'd0, 1'b0, 64'd10); set_lane(1, 5'd11, 5'd0, 5'd0, 1'b0, 64'd11);
        tick();
        clear_in(); set_lane(0, 5'd12, 5'd0, 5'd0, 1'b0, 64'd12); set_lane(1, 5'd13, 5'd0, 5'd0, 1'b0, 64'd13);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_half_ready got=%b exp=1", in_ready); else pass_cnt++;
        tick();
        clear_in(); set_lane(0, 5'd20, 5'd0, 5'd0, 1'b0, 64'd99); set_lane(1, 5'd21, 5'd0, 5'd0, 1'b0, 64'd98);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_full_ready got=%b exp=0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b11) $display("FAIL fill_held_valid got=%b exp=11", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd2) $display("FAIL fill_stall got=%0d exp=2", stall_cnt); else pass_cnt++;
        tick(); clear_in();
        total_cnt++; if (out_payload[63:0] !== 64'd10) $display("FAIL fill_ignored got=%0d exp=10", out_payload[63:0]); else pass_cnt++;
        ex_ready = 1'b1;
        tick();
        total_cnt++; if (out_payload !== {64'd13, 64'd12}) $display("FAIL wrap_pair1 got=%h exp=%h", out_payload, {64'd13, 64'd12}); else pass_cnt++;
        ex_ready = 1'b0;
        set_lane(0, 5'd14, 5'd0, 5'd0, 1'b0, 64'd14); set_lane(1, 5'd15, 5'd0, 5'd0, 1'b0, 64'd15);
        tick(); clear_in();
        total_cnt++; if (out_payload[63:0] !== 64'd12) $display("FAIL wrap_hold got=%0d exp=12", out_payload[63:0]); else pass_cnt++;
        ex_ready = 1'b1;
        tick();
        total_cnt++; if (out_payload !== {64'd15, 64'd14}) $display("FAIL wrap_pair2 got=%h exp=%h", out_payload, {64'd15, 64'd14}); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL wrap_empty got=%b exp=00", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd4) $display("FAIL wrap_stall got=%0d exp=4", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_flush_serial();
        ex_ready = 1'b0;
        clear_in(); set_lane(0, 5'd1, 5'd0, 5'd0, 1'b0, 64'd20); set_lane(1, 5'd2, 5'd0, 5'd0, 1'b0, 64'd21);
        tick();
        ex_ready = 1'b1; flush = 1'b1;
        clear_in(); set_lane(0, 5'd3, 5'd0, 5'd0, 1'b0, 64'd30); set_lane(1, 5'd4, 5'd0, 5'd0, 1'b0, 64'd31);
        #1;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL flush_cycle_valid got=%b exp=00", out_valid); else pass_cnt++;
        tick(); flush = 1'b0; clear_in();
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL flush_after_valid got=%b exp=00", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_after_ready got=%b exp=1", in_ready); else pass_cnt++;
        set_lane(0, 5'd9, 5'd0, 5'd0, 1'b1, 64'd40); set_lane(1, 5'd10, 5'd0, 5'd0, 1'b0, 64'd41);
        tick(); clear_in();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL serial_head_valid got=%b exp=01", out_valid); else pass_cnt++;
        total_cnt++; if (out_payload[63:0] !== 64'd40) $display("FAIL serial_head_pl got=%0d exp=40", out_payload[63:0]); else pass_cnt++;
        tick();
        total_cnt++; if (out_payload[63:0] !== 64'd41) $display("FAIL serial_next_pl got=%0d exp=41", out_payload[63:0]); else pass_cnt++;
        tick();
        set_lane(0, 5'd11, 5'd0, 5'd0, 1'b0, 64'd50); set_lane(1, 5'd12, 5'd0, 5'd0, 1'b1, 64'd51);
        tick(); clear_in();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL serial_lane1_valid got=%b exp=01", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_payload[63:0] !== 64'd51) $display("FAIL serial_lane1_pl got=%0d exp=51", out_payload[63:0]); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b0;
        clear_in(); set_lane(0, 5'd1, 5'd0, 5'd0, 1'b0, 64'd60); set_lane(1, 5'd2, 5'd0, 5'd0, 1'b0, 64'd61);
        tick();
        clear_in(); set_lane(0, 5'd3, 5'd0, 5'd0, 1'b0, 64'd62);
        tick(); clear_in();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL three_buffered_ready got=%b exp=0", in_ready); else pass_cnt++;
        reset = 1'b1; tick(); reset = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL midreset_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL midreset_valid got=%b exp=00", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL midreset_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        ex_load_valid = '0; ex_load_dst = '0;
        clear_in();
        tick(); tick();
        test_reset();
        test_dual_issue();
        test_raw();
        test_load_use();
        test_fill_wrap();
        test_flush_serial();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
